// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and detectors.
// Holds the FSM state encoding and the default frame geometry.
package serial_pattern_gen_pkg;

   localparam int DEF_WIDTH = 11;
   localparam int DEF_REP_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Request/serial-output bundle of the pattern generator.
// master: drives start/data/repeat_n; slave: drives dout/dvalid/busy/done.
interface serial_pattern_gen_if
   import serial_pattern_gen_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REP_W = DEF_REP_W
);

   logic             start;
   logic [WIDTH-1:0] data;
   logic [REP_W-1:0] repeat_n;
   logic             dout;
   logic             dvalid;
   logic             busy;
   logic             done;

   modport master (
      output start, data, repeat_n,
      input  dout, dvalid, busy, done
   );

   modport slave (
      input  start, data, repeat_n,
      output dout, dvalid, busy, done
   );

endinterface

// File: rtl/serial_pattern_gen_piso_shreg.sv
// Parallel-in / serial-out shift register, shifts right, zero fill.
// Ports: clk, reset (sync, active low), load, shift, pdata in; sout = bit 0.
module piso_shreg
   import serial_pattern_gen_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] pdata,
   output logic             sout
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= pdata;
      end else if (shift) begin
         q <= {1'b0, q[WIDTH-1:1]};
      end
   end

   assign sout = q[0];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends a captured word LSB first, 1+repeat_n times.
// Ports: clk, reset (sync, active low), bus (slave side of serial_pattern_gen_if).
module serial_pattern_gen
   import serial_pattern_gen_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REP_W = DEF_REP_W
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_pattern_gen_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] shadow;
   logic [REP_W-1:0] rep;
   logic [CNT_W-1:0] cnt;
   logic             sout;
   logic             last_bit;

   assign last_bit = (cnt == LAST);

   piso_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (state == LOAD),
      .shift (state == SHIFT),
      .pdata (shadow),
      .sout  (sout)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = bus.start ? LOAD : IDLE;
         LOAD:    nxt = SHIFT;
         SHIFT: begin
            if (!last_bit) begin
               nxt = SHIFT;
            end else if (rep == '0) begin
               nxt = DONE;
            end else begin
               nxt = LOAD;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Counter clears on the last bit so it never wraps past WIDTH-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow <= '0;
         rep    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shadow <= bus.data;
                  rep    <= bus.repeat_n;
               end
            end
            LOAD: cnt <= '0;
            SHIFT: begin
               if (last_bit) begin
                  cnt <= '0;
                  if (rep != '0) begin
                     rep <= rep - REP_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.dout   = 1'b0;
      bus.dvalid = 1'b0;
      bus.busy   = (state != IDLE);
      bus.done   = 1'b0;
      case (state)
         SHIFT: begin
            bus.dout   = sout;
            bus.dvalid = 1'b1;
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule
